// File: rtl/rtc_pkg.sv
// rtc_pkg -- shared register map, CTRL/STATUS bit positions and reset
// values for the MMU09 kernel-slot interval timer ($FE00-$FE1F).
package rtc_pkg;

   // Register index decoded from the low three address lines.
   typedef enum logic [2:0] {
      RTC_CTRL      = 3'd0,
      RTC_STATUS    = 3'd1,
      RTC_RELOAD_LO = 3'd2,
      RTC_RELOAD_HI = 3'd3,
      RTC_COUNT_LO  = 3'd4,
      RTC_COUNT_HI  = 3'd5,
      RTC_PRESCALE  = 3'd6,
      RTC_TICKS     = 3'd7
   } rtc_reg_e;

   // CTRL bit positions.
   localparam int unsigned RTC_CTRL_EN      = 0;
   localparam int unsigned RTC_CTRL_IE      = 1;
   localparam int unsigned RTC_CTRL_ONESHOT = 2;

   // STATUS bit positions.
   localparam int unsigned RTC_STATUS_PEND  = 0;

   // Reset values.
   localparam logic [15:0] RTC_RELOAD_RST   = 16'hFFFF;
   localparam logic [7:0]  RTC_PRESCALE_RST = 8'hFF;

   // Assemble the CTRL read-back byte from its individual bits.
   function automatic logic [7:0] rtc_ctrl_byte(input logic en,
                                                input logic ie,
                                                input logic oneshot);
      logic [7:0] b;
      b                   = '0;
      b[RTC_CTRL_EN]      = en;
      b[RTC_CTRL_IE]      = ie;
      b[RTC_CTRL_ONESHOT] = oneshot;
      return b;
   endfunction

endpackage

// File: rtl/rtc_timer_if.sv
// rtc_timer_if -- 6809-side register bus and interrupt line of the RTC slot.
// master: the CPU/decoder side; slave: the timer.
interface rtc_timer_if;

   logic       i_cs_n;
   logic       i_rw;
   logic [2:0] i_addr;
   logic [7:0] i_data;
   logic [7:0] o_data;
   logic       o_data_oe;
   logic       o_rtcirq_n;

   modport master (
      output i_cs_n, i_rw, i_addr, i_data,
      input  o_data, o_data_oe, o_rtcirq_n
   );

   modport slave (
      input  i_cs_n, i_rw, i_addr, i_data,
      output o_data, o_data_oe, o_rtcirq_n
   );

endinterface

// File: rtl/rtc_prescaler.sv
// rtc_prescaler -- 8-bit down-counter that divides the E clock.  While
// enabled it counts down; the cycle it sits at zero asserts o_tick, and the
// following edge reloads it from i_load_val.  i_load forces a reload.
module rtc_prescaler
   import rtc_pkg::*;
(
   input  logic       i_eclk,
   input  logic       i_reset,
   input  logic       i_en,
   input  logic       i_load,
   input  logic [7:0] i_load_val,
   output logic       o_tick
);

   logic [7:0] ps;

   assign o_tick = i_en & (ps == '0);

   // Down-count while enabled, reload on wrap or on explicit load.
   always_ff @(posedge i_eclk or negedge i_reset) begin
      if (!i_reset) begin
         ps <= RTC_PRESCALE_RST;
      end else if (i_load || o_tick) begin
         ps <= i_load_val;
      end else if (i_en) begin
         ps <= ps - 8'd1;
      end
   end

endmodule

// File: rtl/rtc_timer.sv
// rtc_timer -- periodic interval timer in the kernel I/O slot.  E clock is
// divided by PRESCALE+1 and then by RELOAD+1; each expiry sets PEND, bumps
// TICKS and drives the active-low FIRQ line when IE is set.
// Optional feature: define RTC_ONESHOT_EN to implement CTRL.ONESHOT.
module rtc_timer
   import rtc_pkg::*;
(
   input  logic        i_eclk,
   input  logic        i_reset,
   rtc_timer_if.slave  bus
);

   rtc_reg_e    reg_idx;
   logic        wr_en;
   logic        rd_en;
   logic        wr_ctrl;
   logic        wr_status;
   logic        wr_reload_lo;
   logic        wr_reload_hi;
   logic        wr_prescale;
   logic        rd_count_lo;

   logic        ctrl_en;
   logic        ctrl_ie;
   logic        ctrl_oneshot;
   logic        pend;
   logic [15:0] reload;
   logic [7:0]  hold;
   logic [7:0]  prescale;
   logic [15:0] count;
   logic [7:0]  count_hi_latch;
   logic [7:0]  ticks;

   logic [15:0] reload_next;
   logic        en_rise;
   logic        tick;
   logic        expiry;
   logic [7:0]  rd_data;

   // Bus decode: i_cs_n is not qualified by E, so strobes are level signals
   // sampled at the rising edge.
   assign reg_idx      = rtc_reg_e'(bus.i_addr);
   assign wr_en        = ~bus.i_cs_n & ~bus.i_rw;
   assign rd_en        = ~bus.i_cs_n &  bus.i_rw;
   assign wr_ctrl      = wr_en & (reg_idx == RTC_CTRL);
   assign wr_status    = wr_en & (reg_idx == RTC_STATUS);
   assign wr_reload_lo = wr_en & (reg_idx == RTC_RELOAD_LO);
   assign wr_reload_hi = wr_en & (reg_idx == RTC_RELOAD_HI);
   assign wr_prescale  = wr_en & (reg_idx == RTC_PRESCALE);
   assign rd_count_lo  = rd_en & (reg_idx == RTC_COUNT_LO);

   // A RELOAD_HI commit on the same edge as a reload must win, so every
   // counter load goes through this look-ahead value.
   assign reload_next = wr_reload_hi ? {bus.i_data, hold} : reload;
   assign en_rise     = wr_ctrl & bus.i_data[RTC_CTRL_EN] & ~ctrl_en;
   assign expiry      = tick & (count == '0);

   rtc_prescaler u_prescaler (
      .i_eclk     (i_eclk),
      .i_reset    (i_reset),
      .i_en       (ctrl_en),
      .i_load     (en_rise),
      .i_load_val (prescale),
      .o_tick     (tick)
   );

   // CTRL EN/IE: bus writes, then a one-shot expiry drops EN.
   always_ff @(posedge i_eclk or negedge i_reset) begin
      if (!i_reset) begin
         ctrl_en <= 1'b0;
         ctrl_ie <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            ctrl_en <= bus.i_data[RTC_CTRL_EN];
            ctrl_ie <= bus.i_data[RTC_CTRL_IE];
         end
         if (expiry && ctrl_oneshot) begin
            ctrl_en <= 1'b0;
         end
      end
   end

`ifdef RTC_ONESHOT_EN
   // CTRL ONESHOT bit storage.
   always_ff @(posedge i_eclk or negedge i_reset) begin
      if (!i_reset) begin
         ctrl_oneshot <= 1'b0;
      end else if (wr_ctrl) begin
         ctrl_oneshot <= bus.i_data[RTC_CTRL_ONESHOT];
      end
   end
`else
   assign ctrl_oneshot = 1'b0;
`endif

   // PEND: set by expiry, cleared by writing 1; set wins a same-edge clear.
   always_ff @(posedge i_eclk or negedge i_reset) begin
      if (!i_reset) begin
         pend <= 1'b0;
      end else if (expiry) begin
         pend <= 1'b1;
      end else if (wr_status && bus.i_data[RTC_STATUS_PEND]) begin
         pend <= 1'b0;
      end
   end

   // RELOAD holding byte and atomic 16-bit commit, plus PRESCALE.
   always_ff @(posedge i_eclk or negedge i_reset) begin
      if (!i_reset) begin
         hold     <= '0;
         reload   <= RTC_RELOAD_RST;
         prescale <= RTC_PRESCALE_RST;
      end else begin
         if (wr_reload_lo) hold     <= bus.i_data;
         if (wr_reload_hi) reload   <= reload_next;
         if (wr_prescale)  prescale <= bus.i_data;
      end
   end

   // Main counter: load on enable, reload on expiry, else decrement per tick.
   always_ff @(posedge i_eclk or negedge i_reset) begin
      if (!i_reset) begin
         count <= '1;
      end else if (en_rise || expiry) begin
         count <= reload_next;
      end else if (tick) begin
         count <= count - 16'd1;
      end
   end

   // Expiry counter, wraps naturally at 8 bits.
   always_ff @(posedge i_eclk or negedge i_reset) begin
      if (!i_reset) begin
         ticks <= '0;
      end else if (expiry) begin
         ticks <= ticks + 8'd1;
      end
   end

   // COUNT_HI snapshot taken by a COUNT_LO read so the pair is coherent.
   always_ff @(posedge i_eclk or negedge i_reset) begin
      if (!i_reset) begin
         count_hi_latch <= '0;
      end else if (rd_count_lo) begin
         count_hi_latch <= count[15:8];
      end
   end

   // Combinational read mux; drives zero when not selected for read.
   always_comb begin
      rd_data = '0;
      if (rd_en) begin
         case (reg_idx)
            RTC_CTRL:      rd_data = rtc_ctrl_byte(ctrl_en, ctrl_ie, ctrl_oneshot);
            RTC_STATUS:    rd_data = {7'b0, pend};
            RTC_RELOAD_LO: rd_data = reload[7:0];
            RTC_RELOAD_HI: rd_data = reload[15:8];
            RTC_COUNT_LO:  rd_data = count[7:0];
            RTC_COUNT_HI:  rd_data = count_hi_latch;
            RTC_PRESCALE:  rd_data = prescale;
            RTC_TICKS:     rd_data = ticks;
            default:       rd_data = '0;
         endcase
      end
   end

   assign bus.o_data     = rd_data;
   assign bus.o_data_oe  = rd_en & i_eclk;
   assign bus.o_rtcirq_n = ~(pend & ctrl_ie);

endmodule

// File: tb/tb_rtc_timer.sv
// tb_rtc_timer -- self-checking bench for rtc_timer.  Expected values come
// from closed-form arithmetic on PRESCALE/RELOAD and elapsed edge counts.
module tb_rtc_timer;
   import rtc_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   rtc_timer_if bus ();

   rtc_timer dut (
      .i_eclk  (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // ---------------- bus helpers ----------------
   task automatic do_reset();
      bus.i_cs_n = 1'b1; bus.i_rw = 1'b1; bus.i_addr = '0; bus.i_data = '0;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [7:0] d, output int unsigned e);
      @(negedge clk);
      bus.i_cs_n = 1'b0; bus.i_rw = 1'b0; bus.i_addr = a; bus.i_data = d;
      @(posedge clk); #1;
      e = cyc;
      bus.i_cs_n = 1'b1; bus.i_rw = 1'b1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      int unsigned e;
      bus_write(a, d, e);
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
      @(negedge clk);
      bus.i_cs_n = 1'b0; bus.i_rw = 1'b1; bus.i_addr = a;
      #1 d = bus.o_data;
      @(posedge clk); #1;
      bus.i_cs_n = 1'b1;
   endtask

   task automatic wait_until(input int unsigned n);
      while (cyc < n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_irq(input int unsigned limit, output int unsigned e);
      e = 0;
      checks++;
      for (int unsigned i = 0; i < limit; i++) begin
         if (bus.o_rtcirq_n === 1'b0) begin e = cyc; return; end
         @(posedge clk); #1;
      end
      errors++;
      $display("FAIL irq_wait: o_rtcirq_n still 1 after %0d cycles, required 0", limit);
   endtask

   task automatic start_timer(input logic [7:0] p, input logic [15:0] r,
                              input logic [7:0] c, output int unsigned e0);
      wr(RTC_PRESCALE, p);
      wr(RTC_RELOAD_LO, r[7:0]);
      wr(RTC_RELOAD_HI, r[15:8]);
      bus_write(RTC_CTRL, c, e0);
   endtask

   // Reference: state k edges after the enabling edge, with EN held high.
   // Ticks land every (p+1) edges; each block of (r+1) ticks is one expiry.
   function automatic void model(input int unsigned p, input int unsigned r,
                                 input int unsigned k,
                                 output int unsigned cnt, output int unsigned nexp);
      int unsigned t;
      t    = k / (p + 1);
      cnt  = r - (t % (r + 1));
      nexp = t / (r + 1);
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [7:0] d;
      logic [7:0] names_exp [8];
      logic [2:0] idx [8];
      do_reset();
      checks++; if (bus.o_rtcirq_n !== 1'b1) begin errors++; $display("FAIL reset_irq: got %b required 1", bus.o_rtcirq_n); end
      checks++; if (bus.o_data !== 8'h00) begin errors++; $display("FAIL reset_odata: got %h required 00", bus.o_data); end
      checks++; if (bus.o_data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b required 0", bus.o_data_oe); end
      idx = '{RTC_CTRL, RTC_STATUS, RTC_RELOAD_LO, RTC_RELOAD_HI, RTC_PRESCALE, RTC_TICKS, RTC_COUNT_HI, RTC_COUNT_LO};
      names_exp = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF};
      for (int i = 0; i < 8; i++) begin
         bus_read(idx[i], d);
         checks++; if (d !== names_exp[i]) begin errors++; $display("FAIL reset_reg%0d: got %h required %h", idx[i], d, names_exp[i]); end
      end
      bus_read(RTC_COUNT_HI, d);
      checks++; if (d !== 8'hFF) begin errors++; $display("FAIL reset_count_hi_snap: got %h required FF", d); end
      // o_data_oe follows E while a read is selected
      @(negedge clk); bus.i_cs_n = 1'b0; bus.i_rw = 1'b1; bus.i_addr = RTC_CTRL;
      #1;
      checks++; if (bus.o_data_oe !== 1'b0) begin errors++; $display("FAIL oe_e_low: got %b required 0", bus.o_data_oe); end
      @(posedge clk); #1;
      checks++; if (bus.o_data_oe !== 1'b1) begin errors++; $display("FAIL oe_e_high: got %b required 1", bus.o_data_oe); end
      bus.i_cs_n = 1'b1; #1;
      checks++; if (bus.o_data_oe !== 1'b0) begin errors++; $display("FAIL oe_deselect: got %b required 0", bus.o_data_oe); end
   endtask

   task automatic test_period();
      int unsigned e0, e1, e2, ec;
      logic [7:0] d;
      do_reset();
      start_timer(8'd3, 16'd4, 8'h03, e0);
      wait_irq(100, e1);
      checks++; if (int'(e1) - int'(e0) != 20) begin errors++; $display("FAIL period_first: got %0d cycles required 20", int'(e1) - int'(e0)); end
      bus_read(RTC_TICKS, d);
      checks++; if (d !== 8'd1) begin errors++; $display("FAIL period_ticks1: got %h required 01", d); end
      bus_write(RTC_STATUS, 8'h01, ec);
      checks++; if (bus.o_rtcirq_n !== 1'b1) begin errors++; $display("FAIL period_clear: got %b required 1", bus.o_rtcirq_n); end
      wait_irq(100, e2);
      checks++; if (int'(e2) - int'(e1) != 20) begin errors++; $display("FAIL period_second: got %0d cycles required 20", int'(e2) - int'(e1)); end
      bus_read(RTC_TICKS, d);
      checks++; if (d !== 8'd2) begin errors++; $display("FAIL period_ticks2: got %h required 02", d); end
   endtask

   task automatic test_oneshot();
      int unsigned e0, e1, e2;
      logic [7:0] d;
      do_reset();
      start_timer(8'd0, 16'd2, 8'h07, e0);
      wait_irq(50, e1);
      checks++; if (int'(e1) - int'(e0) != 3) begin errors++; $display("FAIL oneshot_first: got %0d cycles required 3", int'(e1) - int'(e0)); end
      bus_read(RTC_CTRL, d);
`ifdef RTC_ONESHOT_EN
      checks++; if (d !== 8'h06) begin errors++; $display("FAIL oneshot_ctrl: got %h required 06", d); end
      wait_until(cyc + 100);
      bus_read(RTC_TICKS, d);
      checks++; if (d !== 8'd1) begin errors++; $display("FAIL oneshot_ticks: got %h required 01", d); end
      e2 = e1;
`else
      checks++; if (d !== 8'h03) begin errors++; $display("FAIL periodic_ctrl: got %h required 03", d); end
      wr(RTC_STATUS, 8'h01);
      wait_irq(50, e2);
      checks++; if (int'(e2) - int'(e1) != 3) begin errors++; $display("FAIL periodic_second: got %0d cycles required 3", int'(e2) - int'(e1)); end
`endif
      checks++; if (bus.o_rtcirq_n !== 1'b0) begin errors++; $display("FAIL oneshot_irq_held: got %b required 0 (last %0d)", bus.o_rtcirq_n, e2); end
   endtask

   task automatic test_clear_collision();
      int unsigned e0, ec, e1;
      logic [7:0] d;
      do_reset();
      start_timer(8'd0, 16'd3, 8'h03, e0);
      wait_until(e0 + 3);
      bus_write(RTC_STATUS, 8'h01, ec);   // lands on expiry edge e0+4
      checks++; if (bus.o_rtcirq_n !== 1'b0) begin errors++; $display("FAIL collide_irq: got %b required 0", bus.o_rtcirq_n); end
      bus_read(RTC_STATUS, d);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL collide_pend: got %h required 01", d); end
      bus_write(RTC_STATUS, 8'h01, ec);   // e0+6, no expiry
      checks++; if (bus.o_rtcirq_n !== 1'b1) begin errors++; $display("FAIL plain_clear_irq: got %b required 1", bus.o_rtcirq_n); end
      bus_read(RTC_STATUS, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL plain_clear_pend: got %h required 00", d); end
      wait_irq(20, e1);
      checks++; if (int'(e1) - int'(e0) != 8) begin errors++; $display("FAIL collide_next: got %0d cycles required 8", int'(e1) - int'(e0)); end
   endtask

   task automatic test_reload_commit();
      int unsigned e0, ef, k;
      logic [7:0] lo, hi;
      logic [15:0] exp16;
      // commit while running, picked up at the next expiry (edge e0+12)
      do_reset();
      start_timer(8'd1, 16'd5, 8'h03, e0);
      wr(RTC_RELOAD_LO, 8'h34);
      wr(RTC_RELOAD_HI, 8'h12);
      k = $urandom_range(1, 40);
      wait_until(e0 + 12 + k - 1);
      bus_write(RTC_CTRL, 8'h02, ef);
      exp16 = 16'h1234 - 16'(k / 2);
      bus_read(RTC_COUNT_LO, lo);
      bus_read(RTC_COUNT_HI, hi);
      checks++; if ({hi, lo} !== exp16) begin errors++; $display("FAIL reload_run_count: got %h required %h (k=%0d)", {hi, lo}, exp16, k); end
      bus_read(RTC_RELOAD_LO, lo);
      bus_read(RTC_RELOAD_HI, hi);
      checks++; if ({hi, lo} !== 16'h1234) begin errors++; $display("FAIL reload_readback: got %h required 1234", {hi, lo}); end
      // commit on the very expiry edge (e0+3)
      do_reset();
      start_timer(8'd0, 16'd2, 8'h03, e0);
      wr(RTC_RELOAD_LO, 8'h00);
      wait_until(e0 + 2);
      wr(RTC_RELOAD_HI, 8'h01);
      k = $urandom_range(1, 50);
      wait_until(e0 + 3 + k - 1);
      bus_write(RTC_CTRL, 8'h02, ef);
      exp16 = 16'h0100 - 16'(k);
      bus_read(RTC_COUNT_LO, lo);
      bus_read(RTC_COUNT_HI, hi);
      checks++; if ({hi, lo} !== exp16) begin errors++; $display("FAIL reload_collide_count: got %h required %h (k=%0d)", {hi, lo}, exp16, k); end
      bus_read(RTC_TICKS, lo);
      checks++; if (lo !== 8'd1) begin errors++; $display("FAIL reload_collide_ticks: got %h required 01", lo); end
   endtask

   task automatic test_count_snapshot();
      int unsigned e0, m;
      logic [15:0] r, exp16;
      logic [7:0] lo, hi;
      for (int i = 0; i < 4; i++) begin
         do_reset();
         r = 16'($urandom_range(16'h0200, 16'h0FFF));
         // even passes read exactly at a low-byte rollover
         m = (i % 2 == 0) ? int'(r[7:0]) : $urandom_range(0, 200);
         start_timer(8'd0, r, 8'h01, e0);
         wait_until(e0 + m);
         bus_read(RTC_COUNT_LO, lo);
         bus_read(RTC_COUNT_HI, hi);
         exp16 = r - 16'(m);
         checks++; if ({hi, lo} !== exp16) begin errors++; $display("FAIL snapshot%0d: got %h required %h", i, {hi, lo}, exp16); end
      end
   endtask

   task automatic test_random();
      int unsigned e0, ef, p, r, k, cnt, nexp;
      logic ie, pend;
      logic [7:0] lo, hi, d;
      for (int i = 0; i < 12; i++) begin
         do_reset();
         p  = $urandom_range(0, 7);
         r  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 400) : $urandom_range(0, 12);
         ie = 1'($urandom_range(0, 1));
         k  = $urandom_range(1, 600);
         start_timer(8'(p), 16'(r), {6'b0, ie, 1'b1}, e0);
         wait_until(e0 + k - 1);
         bus_write(RTC_CTRL, {6'b0, ie, 1'b0}, ef);
         model(p, r, k, cnt, nexp);
         pend = (nexp > 0);
         wait_until(cyc + 20);   // frozen interval
         bus_read(RTC_COUNT_LO, lo);
         bus_read(RTC_COUNT_HI, hi);
         checks++; if ({hi, lo} !== 16'(cnt)) begin errors++; $display("FAIL rand%0d_count: got %h required %h (p=%0d r=%0d k=%0d)", i, {hi, lo}, 16'(cnt), p, r, k); end
         bus_read(RTC_TICKS, d);
         checks++; if (d !== 8'(nexp % 256)) begin errors++; $display("FAIL rand%0d_ticks: got %h required %h", i, d, 8'(nexp % 256)); end
         bus_read(RTC_STATUS, d);
         checks++; if (d !== {7'b0, pend}) begin errors++; $display("FAIL rand%0d_pend: got %h required %h", i, d, {7'b0, pend}); end
         bus_read(RTC_CTRL, d);
         checks++; if (d !== {6'b0, ie, 1'b0}) begin errors++; $display("FAIL rand%0d_ctrl: got %h required %h", i, d, {6'b0, ie, 1'b0}); end
         bus_read(RTC_PRESCALE, d);
         checks++; if (d !== 8'(p)) begin errors++; $display("FAIL rand%0d_prescale: got %h required %h", i, d, 8'(p)); end
         checks++; if (bus.o_rtcirq_n !== ~(pend & ie)) begin errors++; $display("FAIL rand%0d_irq: got %b required %b", i, bus.o_rtcirq_n, ~(pend & ie)); end
      end
   endtask

   task automatic test_async_reset();
      int unsigned e0, e1;
      logic [7:0] d;
      logic [7:0] exp_v [8];
      logic [2:0] idx [8];
      do_reset();
      start_timer(8'd0, 16'd1, 8'h03, e0);
      wait_irq(20, e1);
      #2 rst_n = 1'b0;   // mid-phase, away from any clock edge
      #1;
      checks++; if (bus.o_rtcirq_n !== 1'b1) begin errors++; $display("FAIL async_irq: got %b required 1", bus.o_rtcirq_n); end
      @(negedge clk); rst_n = 1'b1;
      idx   = '{RTC_CTRL, RTC_STATUS, RTC_RELOAD_LO, RTC_RELOAD_HI, RTC_PRESCALE, RTC_TICKS, RTC_COUNT_HI, RTC_COUNT_LO};
      exp_v = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF};
      for (int i = 0; i < 8; i++) begin
         bus_read(idx[i], d);
         checks++; if (d !== exp_v[i]) begin errors++; $display("FAIL async_reg%0d: got %h required %h", idx[i], d, exp_v[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_period();
      test_oneshot();
      test_clear_collision();
      test_reload_commit();
      test_count_snapshot();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
